dmem_access_arbiter: RTL
========================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-port, byte-addressed, async-read data RAM between two requesters:
//  port 0 = CPU MEM stage, port 1 = debug/loader unit. Sequences every access.
//  The RAM only writes whole 32-bit words, so byte/halfword stores run as read-modify-write.
//  Sits between the MEM stage/debug unit and the data RAM; it is the RAM's only master.
// PARAMETERS
//  NB_DATA  32  data width; fixed at 32, other values are unsupported
//  NB_ADDR  8   byte address width; matches the RAM instance
// PORTS
//  clk           in   1          system clock, rising edge
//  i_rst         in   1          synchronous reset, active-high
//  i_req         in   2          per-port request; held high until that port's o_ack
//  i_we          in   2          per-port write enable; 0 = load, 1 = store
//  i_size        in   2x2        per-port size: 00 byte, 01 half, 10 word, 11 reserved
//  i_addr        in   2xNB_ADDR  per-port byte address
//  i_wdata       in   2x32       per-port store data, right-justified
//  o_ack         out  2          one-cycle completion pulse, one bit per port
//  o_err         out  1          valid with o_ack; 1 = access rejected
//  o_rdata       out  32         load data, right-justified, zero-extended; valid with o_ack
//  o_ram_we      out  1          RAM write enable
//  o_ram_addr    out  NB_ADDR    RAM byte address
//  o_ram_wdata   out  32         RAM write word
//  i_ram_rdata   in   32         RAM async read word; byte at o_ram_addr is in [31:24]
// BEHAVIOUR
//  Reset values: state IDLE; o_ack=0; o_err=0; o_rdata=0; o_ram_we=0; o_ram_addr=0.
//  Reset state: o_ram_wdata=0; last_gnt=1, so port 0 wins the first tie.
//  FSM: IDLE -> RD -> (WR, stores only) -> DONE -> IDLE.
//  - IDLE: no i_req -> stay. Otherwise pick the winner and latch its fields into req_q.
//    Winner: the only requester; on a tie, the port != last_gnt. Then go to RD.
//  - RD: o_ram_addr = req_q.addr. Capture i_ram_rdata into word_q at the clock edge.
//    Load: extract into o_rdata, then go to DONE.
//    Store: merged = lane_merge(word_q, wdata, size), then go to WR.
//  - WR: o_ram_we=1, o_ram_addr=req_q.addr, o_ram_wdata=merged, then go to DONE.
//  - DONE: o_ack[winner]=1 for exactly one cycle, o_err valid, last_gnt=winner, then go to IDLE.
//  Word writes also pass through RD, so latency is uniform.
//  Latency from req sampled in IDLE to ack cycle: load 2 cycles, store 3 cycles.
//  No back-to-back: at least one IDLE cycle between acks.
//  Lane rules (big-endian, offset 0 = MSB):
//  - Load: byte = {24'b0, rd[31:24]}; half = {16'b0, rd[31:16]}; word = rd.
//  - Store merge: byte = {wd[7:0], rd[23:0]}; half = {wd[15:0], rd[15:0]}; word = wd.
//  Sign extension of loads is not done here; the CPU does it.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=00.
//  Misaligned access or size=11: skip RD/WR and go IDLE -> DONE with o_err=1.
//  On that error path there is no RAM write and o_rdata=0.
//  Addresses wrap modulo 2**NB_ADDR; no range error.
//  Requester contract: i_* fields are held stable while i_req=1. Fields are latched in IDLE.
//  Changes after that point are ignored until the next IDLE.
//  i_req deasserted before ack: the access still completes and the ack is still pulsed.
//  Reset mid-operation: next state is IDLE and no ack is issued.
//  If reset is asserted during the WR cycle, the RAM write at that edge still happens,
//  because o_ram_we is decoded from the current state.
//  Outside WR, o_ram_we is 0 and o_ram_wdata holds its last value.
// STRUCTURE
//  Package dmem_arb_pkg holds:
//  - state encodings ST_IDLE/ST_RD/ST_WR/ST_DONE;
//  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
//  - the port indices PORT_CPU=0 and PORT_DBG=1.
//  One combinational sub-module, dmem_lane_merge, does load extraction, store merge
//  and the alignment check. Arbitration and the FSM stay in this module.
// TESTING
//  1. Reset, then port0 SW 0x11223344 @0x10, then LW @0x10:
//     each gets one o_ack[0] pulse; load o_rdata = 0x11223344.
//  2. SB 0xAA @0x11, then LW @0x10 -> 0x11AA3344.
//     SH 0xBEEF @0x12, then LW @0x10 -> 0x11AABEEF.
//  3. Both ports request in the same cycle, held 4 transactions:
//     grants alternate 0,1,0,1; first ack goes to port 0; acks never overlap.
//  4. SH @0x13 and LW @0x02 -> o_err=1 with ack, after 1 cycle.
//     RAM contents are unchanged and o_ram_we is never asserted.
//  5. Reset asserted in the RD cycle of a store: no write, no ack, state IDLE.
//     Reset asserted in the WR cycle: the write lands and no ack is issued.
//  6. LB @0xFF after SW 0xDEADBEEF @0xFC -> 0x000000EF.
//     SW @0xFE is an error; with NB_ADDR=8 the address wraps without a range error.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and codes for the data-RAM access arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Latched request; the byte address is kept beside it because its width is a parameter.
    typedef struct packed {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        err;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// Big-endian lane handling: load extraction, store merge and alignment check.
module dmem_lane_merge
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] ram_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o,
    output logic        misalign_o
);

    always_comb begin
        load_data_o = ram_word_i;
        merged_o    = wdata_i;
        misalign_o  = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {24'b0, ram_word_i[31:24]};
                merged_o    = {wdata_i[7:0], ram_word_i[23:0]};
            end
            SZ_HALF: begin
                load_data_o = {16'b0, ram_word_i[31:16]};
                merged_o    = {wdata_i[15:0], ram_word_i[15:0]};
                misalign_o  = addr_lo_i[0];
            end
            SZ_WORD: begin
                misalign_o  = |addr_lo_i;
            end
            default: begin
                misalign_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data RAM.
// Sub-word stores are done as read-modify-write of the addressed word.
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req,
    input  logic [1:0]           i_we,
    input  logic [3:0]           i_size,
    input  logic [2*NB_ADDR-1:0] i_addr,
    input  logic [2*NB_DATA-1:0] i_wdata,
    output logic [1:0]           o_ack,
    output logic                 o_err,
    output logic [NB_DATA-1:0]   o_rdata,
    output logic                 o_ram_we,
    output logic [NB_ADDR-1:0]   o_ram_addr,
    output logic [NB_DATA-1:0]   o_ram_wdata,
    input  logic [NB_DATA-1:0]   i_ram_rdata
);

    state_t               state_q, state_d;
    req_t                 req_q, req_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [NB_DATA-1:0]   rdata_q, rdata_d;
    logic [NB_DATA-1:0]   ram_wdata_q, ram_wdata_d;

    logic                 win;
    logic [1:0]           win_size;
    logic [NB_ADDR-1:0]   win_addr;
    logic [NB_DATA-1:0]   win_wdata;
    logic [1:0]           lm_size;
    logic [1:0]           lm_addr_lo;
    logic [31:0]          load_data;
    logic [31:0]          merged;
    logic                 misalign;

    always_comb begin
        if (i_req[PORT_CPU] && i_req[PORT_DBG]) begin
            win = ~last_gnt_q;
        end else if (i_req[PORT_DBG]) begin
            win = PORT_DBG;
        end else begin
            win = PORT_CPU;
        end
        win_size  = win ? i_size[3:2] : i_size[1:0];
        win_addr  = win ? i_addr[2*NB_ADDR-1:NB_ADDR] : i_addr[NB_ADDR-1:0];
        win_wdata = win ? i_wdata[2*NB_DATA-1:NB_DATA] : i_wdata[NB_DATA-1:0];
    end

    // In IDLE the lane unit checks the incoming winner; afterwards it works on the latched request.
    assign lm_size    = (state_q == ST_IDLE) ? win_size : req_q.size;
    assign lm_addr_lo = (state_q == ST_IDLE) ? win_addr[1:0] : addr_q[1:0];

    dmem_lane_merge u_lane (
        .size_i      (lm_size),
        .addr_lo_i   (lm_addr_lo),
        .ram_word_i  (i_ram_rdata),
        .wdata_i     (req_q.wdata),
        .load_data_o (load_data),
        .merged_o    (merged),
        .misalign_o  (misalign)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|i_req) state_d = misalign ? ST_DONE : ST_RD;
            ST_RD:   state_d = req_q.we ? ST_WR : ST_DONE;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ack = 2'b00;
        if (state_q == ST_DONE) o_ack[req_q.port] = 1'b1;
        o_err    = (state_q == ST_DONE) && req_q.err;
        o_ram_we = (state_q == ST_WR);
    end

    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = ram_wdata_q;
    assign o_rdata     = rdata_q;

    always_comb begin
        req_d       = req_q;
        addr_d      = addr_q;
        last_gnt_d  = last_gnt_q;
        rdata_d     = rdata_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    req_d.port  = win;
                    req_d.we    = i_we[win];
                    req_d.size  = win_size;
                    req_d.err   = misalign;
                    req_d.wdata = win_wdata;
                    addr_d      = win_addr;
                    if (misalign) rdata_d = '0;
                end
            end
            ST_RD: begin
                if (req_q.we) begin
                    ram_wdata_d = merged;
                    rdata_d     = '0;
                end else begin
                    rdata_d     = load_data;
                end
            end
            ST_DONE: last_gnt_d = req_q.port;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            req_q       <= '0;
            addr_q      <= '0;
            last_gnt_q  <= 1'b1;
            rdata_q     <= '0;
            ram_wdata_q <= '0;
        end else begin
            req_q       <= req_d;
            addr_q      <= addr_d;
            last_gnt_q  <= last_gnt_d;
            rdata_q     <= rdata_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

endmodule
